alu_issue_stage: RTL and testbench

//   Operand issue stage directly upstream of the combinational 128-bit add/mul ALU.
//   - Buffers {op, a, b} requests in a small FIFO behind a valid/ready handshake.
//   - Drives the head entry onto the ALU operand ports.
//   - Captures the ALU result into a registered, valid/ready output.
//   - Decouples producers from the ALU critical path; the multiplier is comb-only.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_issue_stage_if.sv | 36 +++
 rtl/alu_issue_fifo.sv | 76 +++++++
 rtl/alu_issue_stage.sv | 147 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   ALU_W       default operand/result width
//   ALU_OP_ADD  op encoding for add
//   ALU_OP_MUL  op encoding for mul
//   alu_req_t   one buffered request {op, a, b} at the default width
//   sat_inc32   32-bit increment that sticks at all-ones
package alu_pkg;

   localparam int unsigned ALU_W = 128;

   localparam logic ALU_OP_ADD = 1'b0;
   localparam logic ALU_OP_MUL = 1'b1;

   typedef struct packed {
      logic             op;
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
   } alu_req_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
      return (cnt == '1) ? cnt : cnt + 32'd1;
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake and ALU operand/result bundle for alu_issue_stage.
// Signal names are as seen from the issue stage.
//   v_i/ready_o/op_i/a_i/b_i          request side
//   alu_op_o/alu_a_o/alu_b_o          operands driven to the ALU
//   alu_result_i                      combinational ALU result
//   v_o/ready_i/result_o/op_o         registered result side
// Modports: slave = issue stage, master = producer/consumer/ALU side.
interface alu_issue_stage_if #(
   parameter int unsigned W = alu_pkg::ALU_W
);

   logic         v_i;
   logic         ready_o;
   logic         op_i;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         alu_op_o;
   logic [W-1:0] alu_a_o;
   logic [W-1:0] alu_b_o;
   logic [W-1:0] alu_result_i;
   logic         v_o;
   logic         ready_i;
   logic [W-1:0] result_o;
   logic         op_o;

   modport slave (
      input  v_i, op_i, a_i, b_i, alu_result_i, ready_i,
      output ready_o, alu_op_o, alu_a_o, alu_b_o, v_o, result_o, op_o
   );

   modport master (
      output v_i, op_i, a_i, b_i, alu_result_i, ready_i,
      input  ready_o, alu_op_o, alu_a_o, alu_b_o, v_o, result_o, op_o
   );

endinterface

// File: rtl/alu_issue_fifo.sv
// Synchronous DEPTH-entry request FIFO, no fall-through.
//   clk_i, reset_i  clock, synchronous active-high reset
//   push_i, data_i  write request (ignored when full)
//   pop_i           remove head (ignored when empty)
//   data_o          current head entry
//   full_o, empty_o occupancy flags
// Pointers are log2(DEPTH) bits and wrap naturally; occupancy is a separate count.
module alu_issue_fifo
   import alu_pkg::*;
#(
   parameter type         T     = alu_req_t,
   parameter int unsigned DEPTH = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   T              mem_q [DEPTH];
   T              mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      full_o   = (count_q == (AW+1)'(DEPTH));
      empty_o  = (count_q == '0);
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      data_o   = mem_q[rd_ptr_q];

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand issue stage in front of the combinational add/mul ALU.
// Buffers {op, a, b} requests, presents the head to the ALU, and captures the
// ALU result into a registered valid/ready output.
//   clk_i, reset_i  clock, synchronous active-high reset
//   bus             alu_issue_stage_if.slave: request, ALU and result signals
//   add_cnt_o, mul_cnt_o, stall_cnt_o
//                   saturating 32-bit perf counters, present only when
//                   ALU_ISSUE_PERF_EN is defined
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned W     = ALU_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   alu_issue_stage_if.slave        bus
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]             add_cnt_o,
   output logic [31:0]             mul_cnt_o,
   output logic [31:0]             stall_cnt_o
`endif
);

   typedef struct packed {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } req_t;

   req_t         push_data;
   req_t         head;
   logic         full, empty;
   logic         push, load;

   logic         v_q, v_d;
   logic [W-1:0] result_q, result_d;
   logic         op_q, op_d;
   // Last head seen, so the ALU inputs stay put while the FIFO is empty.
   req_t         hold_q, hold_d;

   alu_issue_fifo #(
      .T     (req_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (load),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      push_data.op = bus.op_i;
      push_data.a  = bus.a_i;
      push_data.b  = bus.b_i;

      // Full blocks a push even if the head pops this cycle.
      bus.ready_o  = !full && !reset_i;
      push         = bus.v_i && bus.ready_o;
      load         = !empty && (!v_q || bus.ready_i);

      bus.alu_op_o = empty ? hold_q.op : head.op;
      bus.alu_a_o  = empty ? hold_q.a  : head.a;
      bus.alu_b_o  = empty ? hold_q.b  : head.b;

      bus.v_o      = v_q;
      bus.result_o = result_q;
      bus.op_o     = op_q;
   end

   always_comb begin
      v_d      = v_q;
      result_d = result_q;
      op_d     = op_q;
      hold_d   = hold_q;

      if (!empty) begin
         hold_d = head;
      end
      if (load) begin
         result_d = bus.alu_result_i;
         op_d     = head.op;
         v_d      = 1'b1;
      end else if (v_q && bus.ready_i) begin
         v_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_q      <= 1'b0;
         result_q <= '0;
         op_q     <= 1'b0;
         hold_q   <= '0;
      end else begin
         v_q      <= v_d;
         result_q <= result_d;
         op_q     <= op_d;
         hold_q   <= hold_d;
      end
   end

`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] add_cnt_q, add_cnt_d;
   logic [31:0] mul_cnt_q, mul_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      add_cnt_d   = add_cnt_q;
      mul_cnt_d   = mul_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (load && (head.op == ALU_OP_ADD)) begin
         add_cnt_d = sat_inc32(add_cnt_q);
      end
      if (load && (head.op == ALU_OP_MUL)) begin
         mul_cnt_d = sat_inc32(mul_cnt_q);
      end
      if (v_q && !bus.ready_i) begin
         stall_cnt_d = sat_inc32(stall_cnt_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         add_cnt_q   <= '0;
         mul_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         add_cnt_q   <= add_cnt_d;
         mul_cnt_q   <= mul_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      add_cnt_o   = add_cnt_q;
      mul_cnt_o   = mul_cnt_q;
      stall_cnt_o = stall_cnt_q;
   end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed stimulus with literal expectations plus
// a queue-based model checked every cycle on the falling clock edge.
// Honours ALU_ISSUE_PERF_EN for the optional counters.
module tb_alu_issue_stage;

   localparam int unsigned W     = 128;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_issue_stage_if #(.W(W)) bus ();

`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] add_cnt, mul_cnt, stall_cnt;
`endif

   alu_issue_stage #(.W(W), .DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .reset_i     (rst),
      .bus         (bus.slave)
`ifdef ALU_ISSUE_PERF_EN
      ,
      .add_cnt_o   (add_cnt),
      .mul_cnt_o   (mul_cnt),
      .stall_cnt_o (stall_cnt)
`endif
   );

   // Combinational ALU: low W bits of sum or product.
   assign bus.alu_result_i = bus.alu_op_o ? (bus.alu_a_o * bus.alu_b_o)
                                          : (bus.alu_a_o + bus.alu_b_o);

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] alu_f(input logic op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] r;
      if (op) r = a * b;
      else    r = a + b;
      return r;
   endfunction

   // ---------------- model ----------------
   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } mreq_t;

   mreq_t        mq[$];
   mreq_t        m_lh;
   mreq_t        m_h;
   mreq_t        m_new;
   logic         m_ov = 1'b0;
   logic [W-1:0] m_res = '0;
   logic         m_op = 1'b0;
   bit           m_started = 1'b0;
   bit           m_acc, m_ld;
   logic [31:0]  m_add = '0, m_mul = '0, m_stall = '0;

   function automatic logic [31:0] sat(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   always @(negedge clk) begin
      if (m_started) begin
         chk("ready_o", {127'b0, bus.ready_o}, {127'b0, (!rst && (mq.size() < DEPTH))});
         chk("v_o", {127'b0, bus.v_o}, {127'b0, m_ov});
         chk("result_o", bus.result_o, m_res);
         chk("op_o", {127'b0, bus.op_o}, {127'b0, m_op});
         if (mq.size() > 0) begin
            chk("alu_op", {127'b0, bus.alu_op_o}, {127'b0, mq[0].op});
            chk("alu_a", bus.alu_a_o, mq[0].a);
            chk("alu_b", bus.alu_b_o, mq[0].b);
         end else begin
            chk("alu_op_hold", {127'b0, bus.alu_op_o}, {127'b0, m_lh.op});
            chk("alu_a_hold", bus.alu_a_o, m_lh.a);
            chk("alu_b_hold", bus.alu_b_o, m_lh.b);
         end
`ifdef ALU_ISSUE_PERF_EN
         chk("add_cnt", {96'b0, add_cnt}, {96'b0, m_add});
         chk("mul_cnt", {96'b0, mul_cnt}, {96'b0, m_mul});
         chk("stall_cnt", {96'b0, stall_cnt}, {96'b0, m_stall});
`endif
      end

      // Advance to the state after the coming rising edge.
      if (rst) begin
         mq.delete();
         m_ov    = 1'b0;
         m_res   = '0;
         m_op    = 1'b0;
         m_lh.op = 1'b0;
         m_lh.a  = '0;
         m_lh.b  = '0;
         m_add   = '0;
         m_mul   = '0;
         m_stall = '0;
         m_started = 1'b1;
      end else if (m_started) begin
         m_acc = bus.v_i && (mq.size() < DEPTH);
         m_ld  = (mq.size() > 0) && (!m_ov || bus.ready_i);
         if (m_ov && !bus.ready_i) m_stall = sat(m_stall);
         if (mq.size() > 0) m_lh = mq[0];
         if (m_ld) begin
            m_h   = mq.pop_front();
            m_res = alu_f(m_h.op, m_h.a, m_h.b);
            m_op  = m_h.op;
            m_ov  = 1'b1;
            if (m_h.op) m_mul = sat(m_mul);
            else        m_add = sat(m_add);
         end else if (m_ov && bus.ready_i) begin
            m_ov = 1'b0;
         end
         if (m_acc) begin
            m_new.op = bus.op_i;
            m_new.a  = bus.a_i;
            m_new.b  = bus.b_i;
            mq.push_back(m_new);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.v_i  = 1'b1;
      bus.op_i = op;
      bus.a_i  = a;
      bus.b_i  = b;
   endtask

   logic [W-1:0] all_ones;
   logic [W-1:0] top_bit;
   logic [W-1:0] k128;

   initial begin
      all_ones = '1;
      top_bit  = '0;
      top_bit[W-1] = 1'b1;

      bus.v_i     = 1'b1;
      bus.op_i    = 1'b0;
      bus.a_i     = 128'd1;
      bus.b_i     = 128'd1;
      bus.ready_i = 1'b1;
      rst         = 1'b1;

      // 1: reset held 3 cycles with v_i high
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_ready", {127'b0, bus.ready_o}, 128'd0);
         chk("rst_v_o", {127'b0, bus.v_o}, 128'd0);
      end
      rst     = 1'b0;
      bus.v_i = 1'b0;
      #1;
      chk("post_rst_ready", {127'b0, bus.ready_o}, 128'd1);
      chk("post_rst_v_o", {127'b0, bus.v_o}, 128'd0);
      step();
      chk("no_push_in_rst", {127'b0, bus.v_o}, 128'd0);
      step();
      chk("no_push_in_rst2", {127'b0, bus.v_o}, 128'd0);

      // 2: single add
      drive(1'b0, 128'd5, 128'd7);
      step();
      bus.v_i = 1'b0;
      chk("add_lat1_v_o", {127'b0, bus.v_o}, 128'd0);
      step();
      chk("add_v_o", {127'b0, bus.v_o}, 128'd1);
      chk("add_result", bus.result_o, 128'd12);
      chk("add_op", {127'b0, bus.op_o}, 128'd0);
      step();
      chk("add_drop", {127'b0, bus.v_o}, 128'd0);

      // 3: wrap and mul, back to back
      drive(1'b0, all_ones, 128'd1);
      step();
      drive(1'b1, top_bit, 128'd2);
      step();
      chk("wrap_add", bus.result_o, 128'd0);
      chk("wrap_add_op", {127'b0, bus.op_o}, 128'd0);
      drive(1'b1, 128'd3, 128'd4);
      step();
      chk("wrap_mul", bus.result_o, 128'd0);
      chk("wrap_mul_op", {127'b0, bus.op_o}, 128'd1);
      bus.v_i = 1'b0;
      step();
      chk("mul_3x4", bus.result_o, 128'd12);
      chk("mul_3x4_v", {127'b0, bus.v_o}, 128'd1);
      step();
      step();

      // 4: back-pressure, 6 offered, 5 accepted
      bus.ready_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         k128 = 128'(k);
         drive(k128[0], 128'd100 + k128, k128 + 128'd2);
         step();
      end
      chk("bp_ready", {127'b0, bus.ready_o}, 128'd0);
      chk("bp_v_o", {127'b0, bus.v_o}, 128'd1);
      chk("bp_res0", bus.result_o, 128'd102);      // 100 + 2
      bus.v_i     = 1'b0;
      bus.ready_i = 1'b1;
      step();
      chk("bp_res1", bus.result_o, 128'd303);      // 101 * 3
      step();
      chk("bp_res2", bus.result_o, 128'd106);      // 102 + 4
      step();
      chk("bp_res3", bus.result_o, 128'd515);      // 103 * 5
      step();
      chk("bp_res4", bus.result_o, 128'd110);      // 104 + 6
      step();
      chk("bp_no_6th", {127'b0, bus.v_o}, 128'd0);

      // 5: reset with 3 queued and v_o high
      bus.ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         k128 = 128'(k);
         drive(1'b0, 128'd50 + k128, 128'd1);
         step();
      end
      bus.v_i = 1'b0;
      chk("mid_v_o", {127'b0, bus.v_o}, 128'd1);
      rst = 1'b1;
      step();
      chk("mid_rst_v_o", {127'b0, bus.v_o}, 128'd0);
      chk("mid_rst_res", bus.result_o, 128'd0);
      rst         = 1'b0;
      bus.ready_i = 1'b1;
      drive(1'b0, 128'd9, 128'd9);
      step();
      bus.v_i = 1'b0;
      step();
      chk("after_rst_res", bus.result_o, 128'd18);
      chk("after_rst_v", {127'b0, bus.v_o}, 128'd1);
      step();
      chk("after_rst_empty", {127'b0, bus.v_o}, 128'd0);
      step();

`ifdef ALU_ISSUE_PERF_EN
      // 6: counters: 3 adds, 2 muls, 4 stall cycles
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("perf_clr", {96'b0, add_cnt}, 128'd0);
      for (int k = 0; k < 5; k++) begin
         drive((k >= 3) ? 1'b1 : 1'b0, 128'd1, 128'd1);
         step();
      end
      bus.v_i = 1'b0;
      step();
      bus.ready_i = 1'b0;
      for (int k = 0; k < 4; k++) step();
      bus.ready_i = 1'b1;
      chk("perf_add", {96'b0, add_cnt}, 128'd3);
      chk("perf_mul", {96'b0, mul_cnt}, 128'd2);
      chk("perf_stall", {96'b0, stall_cnt}, 128'd4);
      step();
      step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
